// File: rtl/spi_target.sv
// spi_target: memory-mapped SPI mode-0 target on the core memory bus.
// Receives 8-bit MSB-first frames from an external initiator and returns a
// byte preloaded by software. All SPI pins are oversampled in the clk domain.
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   mem_we, mem_addr  bus write strobe and byte address
//   mem_data          shared bus data (driven only on reads of this window)
//   spi_sclk, spi_ss, spi_mosi   asynchronous SPI inputs (ss active-low)
//   spi_miso          registered SPI output
//   irq               level interrupt, rx_full | overrun
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 TXDATA  R/W   0x4 RXDATA  R   0x8 STATUS  R/W1C   0xC reads 0
//
// state | meaning
// IDLE  | target not selected, spi_miso held low
// SHIFT | SS active, shifting bits on detected sclk edges

module spi_target #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   inout  wire  [31:0] mem_data,
   input  logic        spi_sclk,
   input  logic        spi_ss,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        irq
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state;
   logic        sclk_s1, sclk_s2, sclk_s3;
   logic        ss_s1, ss_s2, ss_s3;
   logic        mosi_s1, mosi_s2;
   logic        rise, fall, ss_fall, ss_rise;
   logic [7:0]  tx_hold, tx_shift, rx_shift, rx_data;
   logic        tx_valid, rx_full, overrun;
   logic [2:0]  bit_cnt;
   logic        hit, wr_tx, wr_st;
   logic [7:0]  tx_next, rx_next;
   logic [31:0] rdata;

   // Pin synchronizers; the third sclk/ss flop exists only for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         ss_s3   <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= spi_sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         ss_s1   <= spi_ss;
         ss_s2   <= ss_s1;
         ss_s3   <= ss_s2;
         mosi_s1 <= spi_mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign rise    =  sclk_s2 & ~sclk_s3;
   assign fall    = ~sclk_s2 &  sclk_s3;
   assign ss_fall = ~ss_s2   &  ss_s3;
   assign ss_rise =  ss_s2   & ~ss_s3;

   assign hit   = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign wr_tx = mem_we && hit && (mem_addr[3:0] == 4'h0);
   assign wr_st = mem_we && hit && (mem_addr[3:0] == 4'h8);

   // An empty holding register sends all-ones (underrun is silent).
   assign tx_next = tx_valid ? tx_hold : 8'hFF;
   assign rx_next = {rx_shift[6:0], mosi_s2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         spi_miso <= 1'b0;
         tx_hold  <= 8'h00;
         tx_valid <= 1'b0;
         tx_shift <= 8'h00;
         rx_shift <= 8'h00;
         rx_data  <= 8'h00;
         rx_full  <= 1'b0;
         overrun  <= 1'b0;
         bit_cnt  <= 3'd0;
      end else begin
         // W1C clears come first so a same-cycle byte completion wins.
         if (wr_st) begin
            if (mem_data[0]) rx_full <= 1'b0;
            if (mem_data[2]) overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               spi_miso <= 1'b0;
               if (ss_fall) begin
                  tx_shift <= tx_next;
                  tx_valid <= 1'b0;
                  bit_cnt  <= 3'd0;
                  spi_miso <= tx_next[7];
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  spi_miso <= 1'b0;
                  state    <= IDLE;
               end else if (rise) begin
                  rx_shift <= rx_next;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data <= rx_next;
                     rx_full <= 1'b1;
                     if (rx_full) overrun <= 1'b1;
                  end
               end else if (fall) begin
                  // bit_cnt wrapped to 0: the byte just finished, fetch the next one.
                  if (bit_cnt == 3'd0) begin
                     tx_shift <= tx_next;
                     tx_valid <= 1'b0;
                     spi_miso <= tx_next[7];
                  end else begin
                     tx_shift <= {tx_shift[6:0], 1'b0};
                     spi_miso <= tx_shift[6];
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // After any load above, so a colliding load sees the old holding byte.
         if (wr_tx) begin
            tx_hold  <= mem_data[7:0];
            tx_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      rdata = 32'h0;
      case (mem_addr[3:0])
         4'h0:    rdata = {24'h0, tx_hold};
         4'h4:    rdata = {24'h0, rx_data};
         4'h8:    rdata = {28'h0, ~ss_s2, overrun, ~tx_valid, rx_full};
         default: rdata = 32'h0;
      endcase
   end

   assign mem_data = (!mem_we && hit) ? rdata : 32'hz;
   assign irq      = rx_full | overrun;

endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target: directed scenarios plus randomized frames,
// checked against a byte-level model of the target's registers.

module tb_spi_target;

   localparam logic [31:0] BASE = 32'h1000_0400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   wire  [31:0] mem_data;
   logic        tb_drv = 1'b0;
   logic [31:0] tb_val = 32'h0;
   logic        spi_sclk = 1'b0;
   logic        spi_ss = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        irq;

   assign mem_data = tb_drv ? tb_val : 32'hz;

   spi_target #(.BASE_ADDR(BASE)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .spi_sclk (spi_sclk),
      .spi_ss   (spi_ss),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] m_tx_hold = 8'h00;
   logic [7:0] m_rx_data = 8'h00;
   bit         m_tx_valid = 1'b0;
   bit         m_rx_full  = 1'b0;
   bit         m_ovr      = 1'b0;

   logic [7:0] hb_out [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_status(input bit busy);
      return {28'h0, busy, m_ovr, ~m_tx_valid, m_rx_full};
   endfunction

   // Byte the target will shift out next; consumes the holding register.
   function automatic logic [7:0] model_take();
      logic [7:0] v;
      v = m_tx_valid ? m_tx_hold : 8'hFF;
      m_tx_valid = 1'b0;
      return v;
   endfunction

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a;
      mem_we   = 1'b1;
      tb_val   = d;
      tb_drv   = 1'b1;
      @(posedge clk);
      #1;
      mem_we = 1'b0;
      tb_drv = 1'b0;
   endtask

   task automatic reg_write(input logic [3:0] off, input logic [31:0] d);
      bus_write(BASE + 32'(off), d);
      if (off == 4'h0) begin
         m_tx_hold  = d[7:0];
         m_tx_valid = 1'b1;
      end else if (off == 4'h8) begin
         if (d[0]) m_rx_full = 1'b0;
         if (d[2]) m_ovr = 1'b0;
      end
   endtask

   task automatic reg_read(input logic [3:0] off, output logic [31:0] d);
      mem_addr = BASE + 32'(off);
      mem_we   = 1'b0;
      #2;
      d = mem_data;
   endtask

   // Full frame of nb bytes from hb_out; 8-clk sclk period. With collide set,
   // a W1C of rx_full lands on the same clk edge as the last detected rise.
   task automatic host_frame(input int nb, input bit collide);
      logic [7:0]  exp_b, got;
      logic [31:0] d;
      bit          pre_full;
      spi_ss = 1'b0;
      exp_b  = model_take();
      for (int b = 0; b < nb; b++) begin
         got = 8'h00;
         for (int i = 7; i >= 0; i--) begin
            spi_mosi = hb_out[b][i];
            repeat (4) @(posedge clk);
            #1;
            spi_sclk = 1'b1;
            got = {got[6:0], spi_miso};
            pre_full = m_rx_full;
            if (collide && b == nb - 1 && i == 0) begin
               repeat (2) @(posedge clk);
               #1;
               reg_write(4'h8, 32'h1);
               @(posedge clk);
               #1;
            end else begin
               repeat (4) @(posedge clk);
               #1;
            end
            if (i == 0) begin
               if (pre_full) m_ovr = 1'b1;
               m_rx_full = 1'b1;
               m_rx_data = hb_out[b];
            end
            spi_sclk = 1'b0;
         end
         check("miso_byte", 32'(got), 32'(exp_b));
         exp_b = model_take();
      end
      repeat (4) @(posedge clk);
      #1;
      reg_read(4'h8, d);
      check("status_in_ss", d, exp_status(1'b1));
      spi_ss = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reg_read(4'h8, d);
      check("status_after", d, exp_status(1'b0));
      reg_read(4'h4, d);
      check("rxdata", d, 32'(m_rx_data));
      check("irq", 32'(irq), 32'(m_rx_full | m_ovr));
   endtask

   // Frame aborted after nr sclk rises.
   task automatic host_partial(input int nr);
      logic [7:0]  unused_b;
      logic [31:0] d;
      spi_ss   = 1'b0;
      unused_b = model_take();
      for (int k = 0; k < nr; k++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         repeat (4) @(posedge clk);
         #1;
         spi_sclk = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         spi_sclk = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      spi_ss = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reg_read(4'h8, d);
      check("partial_status", d, exp_status(1'b0));
      reg_read(4'h4, d);
      check("partial_rxdata", d, 32'(m_rx_data));
   endtask

   initial begin
      logic [31:0] d;
      int          nb;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset in the middle of a frame
      reg_write(4'h0, 32'hFF);
      spi_ss = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("miso_pre_rst", 32'(spi_miso), 32'h1);
      spi_sclk = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("miso_async_rst", 32'(spi_miso), 32'h0);
      spi_ss   = 1'b1;
      spi_sclk = 1'b0;
      m_tx_hold = 8'h00; m_tx_valid = 1'b0; m_rx_data = 8'h00; m_rx_full = 1'b0; m_ovr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reg_read(4'h8, d);
      check("rst_status", d, 32'h2);
      check("rst_miso", 32'(spi_miso), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      reg_read(4'h0, d);
      check("rst_txdata", d, 32'h0);
      reg_read(4'h4, d);
      check("rst_rxdata", d, 32'h0);
      reg_read(4'hC, d);
      check("reg_c", d, 32'h0);

      // single byte
      reg_write(4'h0, 32'hA5);
      hb_out[0] = 8'h3C;
      host_frame(1, 1'b0);

      // two bytes in one frame, second underruns, overrun flagged
      reg_write(4'h8, 32'h5);
      reg_write(4'h0, 32'h5A);
      hb_out[0] = 8'h11;
      hb_out[1] = 8'h22;
      host_frame(2, 1'b0);
      reg_write(4'h8, 32'h5);
      reg_read(4'h8, d);
      check("w1c_status", d, 32'h2);
      check("w1c_irq", 32'(irq), 32'h0);

      // aborted frame, then a clean frame
      host_partial(5);
      reg_write(4'h0, 32'h96);
      hb_out[0] = 8'($urandom_range(0, 255));
      host_frame(1, 1'b0);

      // W1C of rx_full colliding with byte completion
      reg_write(4'h0, 32'h3E);
      hb_out[0] = 8'h81;
      host_frame(1, 1'b1);
      reg_write(4'h8, 32'h5);

      // randomized frames
      for (int f = 0; f < 16; f++) begin
         nb = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 1) reg_write(4'h0, 32'($urandom_range(0, 255)));
         for (int b = 0; b < nb; b++) hb_out[b] = 8'($urandom_range(0, 255));
         host_frame(nb, 1'b0);
         if ($urandom_range(0, 1) == 1) reg_write(4'h8, 32'($urandom_range(0, 7)) & 32'h5);
      end

      // bus must not be driven outside the window or during writes
      reg_write(4'h0, 32'hC3);
      tb_val   = 32'h0;
      tb_drv   = 1'b1;
      mem_we   = 1'b0;
      mem_addr = BASE + 32'h10;
      #2;
      check("hiz_out_of_window", mem_data, 32'h0);
      #1;
      mem_addr = BASE;
      mem_we   = 1'b1;
      #2;
      check("hiz_on_write", mem_data, 32'h0);
      #1;
      mem_we = 1'b0;
      tb_drv = 1'b0;
      #1;
      reg_read(4'h0, d);
      check("txdata_readback", d, 32'(m_tx_hold));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
